// File: rtl/spike_filter_sched.sv
// Round-robin tag/count arbiter in front of the filter array, plus the periodic decay-update sequencer.
// Define SPIKE_FILTER_SCHED_OVERRUN_EN to build the saturating lost-tick counter; otherwise overrun reads 0.
//
// state | meaning
// IDLE  | waiting; a pending tick wins over requests
// SEND  | holding the granted tag/count until out_a
// TICK  | single-cycle update_pulse, clears tick_due
module spike_filter_sched #(
  parameter int NReq = 2,
  parameter int Ntag = 10,
  parameter int Nct  = 10,
  parameter int Nper = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [Nper-1:0]      period,
  input  logic [NReq-1:0]      in_v,
  input  logic [NReq*Ntag-1:0] in_tag,
  input  logic [NReq*Nct-1:0]  in_ct,
  output logic [NReq-1:0]      in_a,
  output logic                 out_v,
  output logic [Ntag-1:0]      out_tag,
  output logic [Nct-1:0]       out_ct,
  input  logic                 out_a,
  output logic                 update_pulse,
  output logic [7:0]           overrun
);

  localparam int PW = (NReq > 1) ? $clog2(NReq) : 1;

  typedef enum logic [1:0] {IDLE, SEND, TICK} state_t;

  state_t          state_q, state_d;
  logic [Nper-1:0] cnt_q, cnt_d;
  logic            tick;
  logic            tick_due_q, tick_due_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]   gnt_idx, cand;
  logic            gnt_found;
  logic [NReq-1:0] in_a_q, in_a_d;
  logic            out_v_q, out_v_d;
  logic [Ntag-1:0] out_tag_q, out_tag_d;
  logic [Nct-1:0]  out_ct_q, out_ct_d;
  logic            update_pulse_q, update_pulse_d;
  logic [Ntag-1:0] tag_arr [NReq];
  logic [Nct-1:0]  ct_arr  [NReq];

  always_comb begin
    for (int i = 0; i < NReq; i++) begin
      tag_arr[i] = in_tag[i*Ntag +: Ntag];
      ct_arr[i]  = in_ct[i*Nct +: Nct];
    end
  end

  // >= rather than == so a period shrunk below the running count wraps next clock
  always_comb begin
    cnt_d = '0;
    tick  = 1'b0;
    if (period != '0) begin
      if (cnt_q >= period - Nper'(1)) begin
        tick = 1'b1;
      end else begin
        cnt_d = cnt_q + Nper'(1);
      end
    end
  end

  // a tick landing in the TICK cycle re-arms tick_due instead of counting as lost
  assign tick_due_d = tick | (tick_due_q & (state_q != TICK));

  // scan from the pointer; iterating downward lets the nearest valid requester win
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int i = NReq - 1; i >= 0; i--) begin
      cand = PW'((int'(rr_ptr_q) + i) % NReq);
      if (in_v[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    in_a_d         = '0;
    out_v_d        = out_v_q;
    out_tag_d      = out_tag_q;
    out_ct_d       = out_ct_q;
    update_pulse_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick_due_q) begin
          state_d        = TICK;
          update_pulse_d = 1'b1;
        end else if (gnt_found) begin
          state_d   = SEND;
          out_v_d   = 1'b1;
          out_tag_d = tag_arr[gnt_idx];
          out_ct_d  = ct_arr[gnt_idx];
          in_a_d    = NReq'(1) << gnt_idx;
          rr_ptr_d  = (gnt_idx == PW'(NReq - 1)) ? '0 : gnt_idx + 1'b1;
        end
      end
      SEND: begin
        if (out_a) begin
          out_v_d = 1'b0;
          state_d = IDLE;
        end
      end
      TICK:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      tick_due_q     <= 1'b0;
      rr_ptr_q       <= '0;
      in_a_q         <= '0;
      out_v_q        <= 1'b0;
      out_tag_q      <= '0;
      out_ct_q       <= '0;
      update_pulse_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      tick_due_q     <= tick_due_d;
      rr_ptr_q       <= rr_ptr_d;
      in_a_q         <= in_a_d;
      out_v_q        <= out_v_d;
      out_tag_q      <= out_tag_d;
      out_ct_q       <= out_ct_d;
      update_pulse_q <= update_pulse_d;
    end
  end

`ifdef SPIKE_FILTER_SCHED_OVERRUN_EN
  logic [7:0] overrun_q, overrun_d;

  always_comb begin
    overrun_d = overrun_q;
    if (tick && tick_due_q && (state_q != TICK) && (overrun_q != 8'hFF)) begin
      overrun_d = overrun_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun_q <= '0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  assign overrun = overrun_q;
`else
  assign overrun = '0;
`endif

  assign in_a         = in_a_q;
  assign out_v        = out_v_q;
  assign out_tag      = out_tag_q;
  assign out_ct       = out_ct_q;
  assign update_pulse = update_pulse_q;

endmodule

// File: tb/tb_spike_filter_sched.sv
// Directed bench for spike_filter_sched: update cadence, round-robin grants, tick deferral,
// lost-tick accounting, period=0 handling and mid-transfer reset.
module tb_spike_filter_sched;

  localparam int NReq = 2;
  localparam int Ntag = 10;
  localparam int Nct  = 10;
  localparam int Nper = 16;

`ifdef SPIKE_FILTER_SCHED_OVERRUN_EN
  localparam logic [31:0] OVR4 = 32'd4;
`else
  localparam logic [31:0] OVR4 = 32'd0;
`endif

  logic                 clk = 1'b0;
  logic                 reset;
  logic [Nper-1:0]      period;
  logic [NReq-1:0]      in_v;
  logic [NReq*Ntag-1:0] in_tag;
  logic [NReq*Nct-1:0]  in_ct;
  logic [NReq-1:0]      in_a;
  logic                 out_v;
  logic [Ntag-1:0]      out_tag;
  logic [Nct-1:0]       out_ct;
  logic                 out_a;
  logic                 update_pulse;
  logic [7:0]           overrun;

  int   n_tests = 0;
  int   n_fail  = 0;
  logic ack_mode  = 1'b0;
  logic v_prev    = 1'b0;
  logic outv_seen = 1'b0;

  spike_filter_sched #(.NReq(NReq), .Ntag(Ntag), .Nct(Nct), .Nper(Nper)) dut (
    .clk          (clk),
    .reset        (reset),
    .period       (period),
    .in_v         (in_v),
    .in_tag       (in_tag),
    .in_ct        (in_ct),
    .in_a         (in_a),
    .out_v        (out_v),
    .out_tag      (out_tag),
    .out_ct       (out_ct),
    .out_a        (out_a),
    .update_pulse (update_pulse),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // registered sink when ack_mode is set: acks in the second cycle out_v is seen high
  task automatic step();
    @(posedge clk);
    #1;
    if (out_v) outv_seen = 1'b1;
    if (ack_mode) out_a = out_v & v_prev;
    v_prev = out_v;
  endtask

  task automatic wait_pulse(input int max, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!update_pulse && n < max);
  endtask

  task automatic wait_ina(input int max, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (in_a == '0 && n < max);
  endtask

  // leaves reset released just after an edge; the next edge is the first active one
  task automatic apply_reset(input logic [Nper-1:0] per);
    reset    = 1'b0;
    period   = per;
    in_v     = '0;
    out_a    = 1'b0;
    ack_mode = 1'b0;
    v_prev   = 1'b0;
    repeat (2) step();
    chk_eq("reset_outputs", {in_a, out_v, out_tag, out_ct, update_pulse, overrun}, 32'd0);
    reset     = 1'b1;
    outv_seen = 1'b0;
  endtask

  initial begin
    int n;
    int cnt;
    int bad;
    reset  = 1'b0;
    period = '0;
    in_v   = '0;
    in_tag = '0;
    in_ct  = '0;
    out_a  = 1'b0;

    // period 64, no traffic: first pulse period+1 edges after release, then every 64
    apply_reset(16'd64);
    wait_pulse(200, n);
    chk_eq("first_pulse_lat", 32'(n), 32'd65);
    step();
    chk_eq("pulse_width", 32'(update_pulse), 32'd0);
    wait_pulse(200, n);
    chk_eq("pulse_spacing", 32'(n), 32'd63);
    chk_eq("idle_out_v", 32'(outv_seen), 32'd0);

    // both requesters valid: grants alternate, one transfer per 3 clocks
    apply_reset(16'd0);
    in_tag   = {10'd1, 10'd0};
    in_ct    = {10'd2, 10'd1};
    in_v     = 2'b11;
    ack_mode = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_ina(20, n);
      chk_eq("rr_spacing", 32'(n), (k == 0) ? 32'd1 : 32'd3);
      chk_eq("rr_in_a", 32'(in_a), (k % 2 == 0) ? 32'd1 : 32'd2);
      chk_eq("rr_tag", 32'(out_tag), 32'(k % 2));
      chk_eq("rr_ct", 32'(out_ct), 32'(k % 2 + 1));
    end
    ack_mode = 1'b0;
    in_v     = '0;

    // ack held off 10 clocks with a tick at edge 8: pulse waits for the ack
    apply_reset(16'd8);
    in_tag = {10'd0, 10'h155};
    in_ct  = {10'd0, 10'h2AA};
    in_v   = 2'b01;
    step();
    chk_eq("dly_grant", 32'(in_a), 32'd1);
    in_v = '0;
    cnt = 0;
    bad = 0;
    repeat (10) begin
      step();
      if (update_pulse) cnt++;
      if (out_v !== 1'b1 || out_tag !== 10'h155 || out_ct !== 10'h2AA) bad++;
    end
    chk_eq("dly_no_pulse", 32'(cnt), 32'd0);
    chk_eq("dly_stable", 32'(bad), 32'd0);
    out_a = 1'b1;
    step();
    out_a = 1'b0;
    chk_eq("dly_out_v_low", 32'(out_v), 32'd0);
    chk_eq("dly_pulse_wait", 32'(update_pulse), 32'd0);
    step();
    chk_eq("dly_pulse", 32'(update_pulse), 32'd1);
    step();
    chk_eq("dly_pulse_width", 32'(update_pulse), 32'd0);

    // period 4, no ack for 20 clocks: ticks at edges 4,8,12,16,20 -> four lost
    apply_reset(16'd4);
    in_tag = {10'd0, 10'h3C3};
    in_ct  = {10'd0, 10'd7};
    in_v   = 2'b01;
    step();
    chk_eq("ovr_grant", 32'(out_v), 32'd1);
    in_v = '0;
    cnt = 0;
    repeat (20) begin
      step();
      if (update_pulse) cnt++;
    end
    chk_eq("ovr_no_pulse", 32'(cnt), 32'd0);
    chk_eq("ovr_count", 32'(overrun), OVR4);
    out_a  = 1'b1;
    period = '0;
    step();
    out_a = 1'b0;
    chk_eq("ovr_done", 32'(out_v), 32'd0);
    cnt = 0;
    repeat (12) begin
      step();
      if (update_pulse) cnt++;
    end
    chk_eq("ovr_pulses", 32'(cnt), 32'd1);
    chk_eq("ovr_hold", 32'(overrun), OVR4);

    // period dropped to 0 with a tick pending, then restored to 8
    apply_reset(16'd8);
    repeat (8) step();
    chk_eq("p0_pre_pulse", 32'(update_pulse), 32'd0);
    period = '0;
    cnt = 0;
    repeat (20) begin
      step();
      if (update_pulse) cnt++;
    end
    chk_eq("p0_pulses", 32'(cnt), 32'd1);
    period = 16'd8;
    wait_pulse(40, n);
    chk_eq("resume_first", 32'(n), 32'd9);
    wait_pulse(40, n);
    chk_eq("resume_spacing", 32'(n), 32'd8);

    // reset while req0 is in SEND (pointer at 1); afterwards req0 must win again
    apply_reset(16'd0);
    in_tag = {10'd1, 10'd0};
    in_ct  = {10'd2, 10'd1};
    in_v   = 2'b11;
    step();
    chk_eq("mid_pre_in_a", 32'(in_a), 32'd1);
    #3;
    reset = 1'b0;
    #1;
    chk_eq("mid_out_v", 32'(out_v), 32'd0);
    chk_eq("mid_in_a", 32'(in_a), 32'd0);
    chk_eq("mid_pulse", 32'(update_pulse), 32'd0);
    step();
    reset = 1'b1;
    step();
    chk_eq("restart_in_a", 32'(in_a), 32'd1);
    chk_eq("restart_tag", 32'(out_tag), 32'd0);
    chk_eq("restart_ct", 32'(out_ct), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
